// File: rtl/prog_loader_pkg.sv
// Shared processor package for the program loader.
// Holds the loader state encoding, the word access-size code and the
// default load address.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_OVFL = 2'd3
  } loader_state_e;

  localparam logic [1:0]  ACC_WORD       = 2'b00;
  localparam logic [31:0] START_ADDR_DEF = 32'h8002_0000;

endpackage

// File: rtl/prog_loader_if.sv
// Program-loader bus: word stream in (valid/ready/last) and memory write
// port out. Data and address are [0:31] with bit 0 as the MSB.
//   slave  : the loader side (consumes words, drives memory)
//   master : the source/memory side
interface prog_loader_if;
  logic        word_valid;
  logic [0:31] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_busy;
  logic [0:31] mem_addr;
  logic [0:31] mem_data_in;
  logic        mem_wren;
  logic [1:0]  mem_acc_size;
  logic        mem_enable;

  modport slave (
    input  word_valid, word_data, word_last, mem_busy,
    output word_ready, mem_addr, mem_data_in, mem_wren, mem_acc_size, mem_enable
  );

  modport master (
    output word_valid, word_data, word_last, mem_busy,
    input  word_ready, mem_addr, mem_data_in, mem_wren, mem_acc_size, mem_enable
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: after a start pulse, accepts a stream of 32-bit words and
// writes them to consecutive word addresses from START_ADDRESS, one cycle
// after each acceptance. Ends in DONE on word_last, or in OVFL when
// MAX_WORDS words arrive without word_last.
// Ports:
//   clock, reset   sole clock, synchronous active-high reset
//   start          single-cycle pulse, (re)starts a load outside LOAD
//   bus            prog_loader_if.slave: word stream + memory write port
//   stall          low only in DONE (releases the fetch stage)
//   word_count     words written in the current load
//   done/overflow  high in DONE / OVFL
//   checksum       running sum of written words
// Optional feature: define LOADER_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = START_ADDR_DEF,
  parameter int unsigned MAX_WORDS     = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          stall,
  output logic [31:0]   word_count,
  output logic          done,
  output logic          overflow,
  output logic [31:0]   checksum
);

  localparam logic [31:0] LAST_IDX = 32'(MAX_WORDS - 1);

  loader_state_e state;
  logic          wren_q;
  logic          accept;
  logic          ends_load;

  // Reset gates the handshake and the write strobe combinationally so that
  // a write registered on the previous edge never reaches memory while
  // reset is held, and no word is taken in a reset cycle.
  assign bus.word_ready = !reset && (state == ST_LOAD) && !bus.mem_busy
                          && !(wren_q && bus.mem_busy);
  assign accept         = bus.word_valid && bus.word_ready;
  assign bus.mem_wren   = wren_q && !reset;
  assign bus.mem_acc_size = ACC_WORD;

  // The word that fills capacity (count == MAX_WORDS-1 before increment)
  // or carries word_last closes the load.
  assign ends_load = bus.word_last || (word_count == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      wren_q         <= 1'b0;
      bus.mem_addr   <= START_ADDRESS;
      bus.mem_data_in <= '0;
      bus.mem_enable <= 1'b0;
      word_count     <= '0;
      stall          <= 1'b1;
      done           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      wren_q <= accept;
      if (accept) begin
        bus.mem_addr    <= START_ADDRESS + {word_count[29:0], 2'b00};
        bus.mem_data_in <= bus.word_data;
        word_count      <= word_count + 32'd1;
      end
      case (state)
        ST_LOAD: begin
          // Leaving LOAD on the closing acceptance stops further handshakes;
          // that word's write lands in the first DONE/OVFL cycle.
          if (accept && ends_load) begin
            state    <= bus.word_last ? ST_DONE : ST_OVFL;
            stall    <= !bus.word_last;
            done     <= bus.word_last;
            overflow <= !bus.word_last;
          end
        end
        default: begin
          if (start) begin
            state          <= ST_LOAD;
            word_count     <= '0;
            bus.mem_enable <= 1'b1;
            stall          <= 1'b1;
            done           <= 1'b0;
            overflow       <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Accumulates in the write cycle; a (re)start clears it.
  always_ff @(posedge clock) begin
    if (reset || (start && state != ST_LOAD))
      checksum <= '0;
    else if (wren_q)
      checksum <= checksum + bus.mem_data_in;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (MAX_WORDS=4): streaming, busy
// back-pressure, overflow, last-at-capacity, reset during a write, checksum.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall, done, overflow;
  logic [31:0] word_count, checksum;
  int          errs = 0;
  int          checks = 0;

  prog_loader_if bus ();

  prog_loader #(.START_ADDRESS(32'h8002_0000), .MAX_WORDS(4)) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .stall(stall), .word_count(word_count), .done(done),
    .overflow(overflow), .checksum(checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] cs_exp(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
    return sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk_wr(input string tag, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] cnt);
    chk({tag, ".wren"}, 32'(bus.mem_wren), 32'd1);
    chk({tag, ".addr"}, bus.mem_addr, addr);
    chk({tag, ".data"}, bus.mem_data_in, data);
    chk({tag, ".cnt"}, word_count, cnt);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_last  = 1'b0;
    bus.mem_busy   = 1'b0;

    // reset state
    tick(); tick();
    chk("rst.wren",   32'(bus.mem_wren), 32'd0);
    chk("rst.ready",  32'(bus.word_ready), 32'd0);
    chk("rst.enable", 32'(bus.mem_enable), 32'd0);
    chk("rst.addr",   bus.mem_addr, 32'h8002_0000);
    chk("rst.data",   bus.mem_data_in, 32'h0);
    chk("rst.size",   32'(bus.mem_acc_size), 32'd0);
    chk("rst.cnt",    word_count, 32'd0);
    chk("rst.stall",  32'(stall), 32'd1);
    chk("rst.done",   32'(done), 32'd0);
    chk("rst.ovfl",   32'(overflow), 32'd0);
    chk("rst.cs",     checksum, 32'h0);
    reset = 1'b0;
    tick();
    chk("idle.ready", 32'(bus.word_ready), 32'd0);

    // three-word stream, no stalls
    do_start();
    chk("s1.ready",  32'(bus.word_ready), 32'd1);
    chk("s1.enable", 32'(bus.mem_enable), 32'd1);
    chk("s1.stall",  32'(stall), 32'd1);
    bus.word_valid = 1'b1; bus.word_data = 32'h1111_0001;
    tick(); chk_wr("s1.w0", 32'h8002_0000, 32'h1111_0001, 32'd1);
    bus.word_data = 32'h2222_0002;
    tick(); chk_wr("s1.w1", 32'h8002_0004, 32'h2222_0002, 32'd2);
    bus.word_data = 32'h3333_0003; bus.word_last = 1'b1;
    tick(); chk_wr("s1.w2", 32'h8002_0008, 32'h3333_0003, 32'd3);
    bus.word_valid = 1'b0; bus.word_last = 1'b0;
    tick();
    chk("s1.wren0", 32'(bus.mem_wren), 32'd0);
    chk("s1.hold",  bus.mem_addr, 32'h8002_0008);
    chk("s1.done",  32'(done), 32'd1);
    chk("s1.stall0", 32'(stall), 32'd0);
    chk("s1.cnt",   word_count, 32'd3);
    chk("s1.ready0", 32'(bus.word_ready), 32'd0);
    chk("s1.cs",    checksum, cs_exp(32'h6666_0006));

    // busy for two cycles mid-stream; start inside LOAD is ignored
    do_start();
    chk("s2.done0", 32'(done), 32'd0);
    chk("s2.cnt0",  word_count, 32'd0);
    bus.word_valid = 1'b1; bus.word_data = 32'hA000_0000;
    tick(); chk_wr("s2.w0", 32'h8002_0000, 32'hA000_0000, 32'd1);
    bus.word_data = 32'hA000_0001; bus.mem_busy = 1'b1; start = 1'b1;
    #1 chk("s2.busy1", 32'(bus.word_ready), 32'd0);
    tick(); start = 1'b0;
    chk("s2.nowr1", 32'(bus.mem_wren), 32'd0);
    chk("s2.busy2", 32'(bus.word_ready), 32'd0);
    chk("s2.cnt1",  word_count, 32'd1);
    tick();
    chk("s2.nowr2", 32'(bus.mem_wren), 32'd0);
    bus.mem_busy = 1'b0;
    #1 chk("s2.ready", 32'(bus.word_ready), 32'd1);
    tick(); chk_wr("s2.w1", 32'h8002_0004, 32'hA000_0001, 32'd2);
    bus.word_data = 32'hA000_0002; bus.word_last = 1'b1;
    tick(); chk_wr("s2.w2", 32'h8002_0008, 32'hA000_0002, 32'd3);
    bus.word_valid = 1'b0; bus.word_last = 1'b0;
    tick();
    chk("s2.done", 32'(done), 32'd1);
    chk("s2.cnt",  word_count, 32'd3);

    // five words without last at capacity 4
    do_start();
    bus.word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.word_data = 32'hB000_0000 + 32'(i);
      tick();
      chk_wr($sformatf("s3.w%0d", i), 32'h8002_0000 + 32'(4 * i),
             32'hB000_0000 + 32'(i), 32'(i + 1));
    end
    bus.word_data = 32'hB000_0004;
    #1 chk("s3.ready5", 32'(bus.word_ready), 32'd0);
    tick();
    chk("s3.nowr5", 32'(bus.mem_wren), 32'd0);
    chk("s3.ovfl",  32'(overflow), 32'd1);
    chk("s3.done",  32'(done), 32'd0);
    chk("s3.stall", 32'(stall), 32'd1);
    chk("s3.cnt",   word_count, 32'd4);
    chk("s3.hold",  bus.mem_addr, 32'h8002_000C);
    tick();
    chk("s3.nowr6", 32'(bus.mem_wren), 32'd0);
    bus.word_valid = 1'b0;

    // last on the fourth word: DONE, not OVFL
    do_start();
    chk("s4.ovfl0", 32'(overflow), 32'd0);
    bus.word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.word_data = 32'hC000_0000 + 32'(i);
      bus.word_last = (i == 3);
      tick();
      chk_wr($sformatf("s4.w%0d", i), 32'h8002_0000 + 32'(4 * i),
             32'hC000_0000 + 32'(i), 32'(i + 1));
    end
    bus.word_valid = 1'b0; bus.word_last = 1'b0;
    tick();
    chk("s4.done", 32'(done), 32'd1);
    chk("s4.ovfl", 32'(overflow), 32'd0);
    chk("s4.cnt",  word_count, 32'd4);

    // reset in the cycle after an acceptance
    do_start();
    bus.word_valid = 1'b1; bus.word_data = 32'hD000_0000;
    tick();
    bus.word_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("s5.wren",  32'(bus.mem_wren), 32'd0);
    chk("s5.ready", 32'(bus.word_ready), 32'd0);
    tick();
    chk("s5.wren2",  32'(bus.mem_wren), 32'd0);
    chk("s5.addr",   bus.mem_addr, 32'h8002_0000);
    chk("s5.data",   bus.mem_data_in, 32'h0);
    chk("s5.cnt",    word_count, 32'd0);
    chk("s5.enable", 32'(bus.mem_enable), 32'd0);
    chk("s5.stall",  32'(stall), 32'd1);
    chk("s5.done",   32'(done), 32'd0);
    chk("s5.ovfl",   32'(overflow), 32'd0);
    chk("s5.cs",     checksum, 32'h0);
    reset = 1'b0;
    tick();

    // checksum wraps modulo 2^32
    do_start();
    bus.word_valid = 1'b1; bus.word_data = 32'hFFFF_FFFF;
    tick();
    bus.word_data = 32'h0000_0002; bus.word_last = 1'b1;
    tick();
    bus.word_valid = 1'b0; bus.word_last = 1'b0;
    tick(); tick();
    chk("s6.done", 32'(done), 32'd1);
    chk("s6.cs",   checksum, cs_exp(32'h0000_0001));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter START_ADDRESS, default 32'h80020000, byte address of the first program word.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, capacity in 32-bit words.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a load.
REQ-007 word_valid  input  1  source presents a program word.
REQ-008 word_data  input  32 [0:31]  program word; bit 0 is the MSB.
REQ-009 word_last  input  1  qualifies word_data as the final word.
REQ-010 word_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_busy  input  1  memory busy.
REQ-012 mem_addr  output  32 [0:31]  memory byte address.
REQ-013 mem_data_in  output  32 [0:31]  memory write data.
REQ-014 mem_wren  output  1  memory write strobe.
REQ-015 mem_acc_size  output  2  access size; constant 2'b00 (word).
REQ-016 mem_enable  output  1  memory enable.
REQ-017 stall  output  1  holds fetch stage off while high.
REQ-018 word_count  output  32  number of words written.
REQ-019 done  output  1  load completed.
REQ-020 overflow  output  1  load aborted at capacity.
REQ-021 checksum  output  32  running word sum (see Configuration).

Function
REQ-022 SHALL implement states IDLE, LOAD, DONE and OVFL.
REQ-023 IDLE: start=1 -> LOAD; word_count cleared to 0; checksum cleared to 0.
REQ-024 SHALL assert word_ready = (state==LOAD) && !mem_busy && !(mem_wren && mem_busy).
REQ-025 SHALL treat a word as accepted when word_valid && word_ready are both high in the same cycle.
REQ-026 For an accepted word, the next cycle SHALL drive mem_wren=1, mem_data_in=word_data, and mem_addr=START_ADDRESS+4*word_count (pre-increment value).
REQ-027 word_count SHALL increment on the cycle after each acceptance.
REQ-028 Write latency SHALL be exactly 1 cycle; mem_wren SHALL be high for exactly one cycle per accepted word and low otherwise.
REQ-029 Back-to-back acceptances SHALL produce consecutive writes at consecutive word addresses.
REQ-030 An accepted word with word_last=1 SHALL cause LOAD -> DONE after its write cycle.
REQ-031 Acceptance of word number MAX_WORDS without word_last SHALL write that word, then go to OVFL; further words SHALL NOT be accepted.
REQ-032 If word_last coincides with word MAX_WORDS, the block SHALL go to DONE, not OVFL.
REQ-033 start SHALL be ignored in LOAD.
REQ-034 start in DONE or OVFL SHALL restart per REQ-023 (go to LOAD).
REQ-035 stall SHALL be 0 only in DONE.
REQ-036 done SHALL be 1 only in DONE; overflow SHALL be 1 only in OVFL.
REQ-037 mem_enable SHALL be 1 in all states except IDLE.
REQ-038 When mem_wren=0, mem_addr SHALL hold its last value.
REQ-039 mem_addr arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-040 On reset: state=IDLE, stall=1, word_ready=0, mem_wren=0, mem_enable=0, mem_addr=START_ADDRESS, mem_data_in=0, word_count=0, checksum=0, done=0, overflow=0.
REQ-041 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-042 Reset during LOAD SHALL suppress any pending write.

Configuration
REQ-043 With LOADER_CHECKSUM_EN defined, checksum SHALL accumulate the 32-bit modulo-2^32 sum of accepted words, updated in the write cycle.
REQ-044 Without LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesised.

Structure
REQ-045 The loader state enum, the ACC_WORD=2'b00 constant and the START_ADDRESS default SHALL reside in the shared processor package.
REQ-046 SHALL be a single module with no sub-modules.

Verification
REQ-047 Stream 3 words (A, B, C; last on C) with no stalls -> writes at 80020000, 80020004 and 80020008 on consecutive cycles; done=1; stall=0; word_count=3.
REQ-048 Hold mem_busy=1 for 2 cycles mid-stream -> word_ready=0 for those cycles; no lost or duplicated words.
REQ-049 MAX_WORDS=4, stream 5 words with no last -> 4 writes; overflow=1; 5th word never accepted; stall=1.
REQ-050 MAX_WORDS=4, last on 4th word -> done=1; overflow=0.
REQ-051 Assert reset in the cycle after acceptance -> no mem_wren; all outputs at reset values.
REQ-052 LOADER_CHECKSUM_EN defined, words FFFFFFFF and 00000002 -> checksum=00000001; with the macro undefined -> checksum=0.
